// File: rtl/asteroid_pixel_pipe.sv
// Two-stage pixel pipeline: object hit testing against frame-latched positions, colour priority and sync delay matching.
// Optional build macro COLLISION_DETECT_EN adds a per-frame player/asteroid overlap flag.
module asteroid_pixel_pipe #(
   parameter int   XBITS     = 10,
   parameter int   YBITS     = 10,
   parameter int   VVISIBLE  = 480,
   parameter int   SIZE      = 16,
   parameter logic SYNC_IDLE = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             pix_en,
   input  logic             hsync_in,
   input  logic             vsync_in,
   input  logic             activevideo_in,
   input  logic [XBITS-1:0] x,
   input  logic [YBITS-1:0] y,
   input  logic             pos_wr,
   input  logic [1:0]       pos_sel,
   input  logic [XBITS-1:0] pos_x,
   input  logic [YBITS-1:0] pos_y,
   output logic             hsync_out,
   output logic             vsync_out,
   output logic [7:0]       rgb,
   output logic             collision,
   output logic             frame_done
);

   localparam logic [XBITS-1:0] X_OFF   = '1;
   localparam logic [YBITS-1:0] Y_OFF   = '1;
   localparam logic [YBITS-1:0] Y_BOUND = VVISIBLE[YBITS-1:0];
   localparam logic [XBITS:0]   SIZE_X  = SIZE[XBITS:0];
   localparam logic [YBITS:0]   SIZE_Y  = SIZE[YBITS:0];

   localparam logic [7:0] RGB_BLANK    = 8'h00;
   localparam logic [7:0] RGB_PLAYER   = 8'h1C;
   localparam logic [7:0] RGB_ASTEROID = 8'hE0;
   localparam logic [7:0] RGB_BG       = 8'h03;

   logic [XBITS-1:0] shd_x_q [4];
   logic [YBITS-1:0] shd_y_q [4];
   logic [XBITS-1:0] act_x_q [4];
   logic [YBITS-1:0] act_y_q [4];

   logic       boundary;
   logic [3:0] hit_d;
   logic       hs1_q, vs1_q, av1_q;
   logic [3:0] hit1_q;
   logic [7:0] rgb_d;
   logic       hs2_q, vs2_q, frame_done_q;
   logic [7:0] rgb_q;

   assign boundary = pix_en && (x == '0) && (y == Y_BOUND);

   // NOTE: the position arrays are few enough to reset as flops, so objects start off-screen instead of at X.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) begin
            shd_x_q[i] <= X_OFF;
            shd_y_q[i] <= Y_OFF;
            act_x_q[i] <= X_OFF;
            act_y_q[i] <= Y_OFF;
         end
      end else begin
         // Copy reads the old shadow, so a coincident write waits for the next frame.
         if (boundary) begin
            for (int i = 0; i < 4; i++) begin
               act_x_q[i] <= shd_x_q[i];
               act_y_q[i] <= shd_y_q[i];
            end
         end
         if (pos_wr) begin
            shd_x_q[pos_sel] <= pos_x;
            shd_y_q[pos_sel] <= pos_y;
         end
      end
   end

   // Upper bounds are one bit wider so objects near the max coordinate clip instead of wrapping.
   always_comb begin
      hit_d = '0;
      for (int i = 0; i < 4; i++) begin
         hit_d[i] = (x >= act_x_q[i]) && ({1'b0, x} < ({1'b0, act_x_q[i]} + SIZE_X)) &&
                    (y >= act_y_q[i]) && ({1'b0, y} < ({1'b0, act_y_q[i]} + SIZE_Y));
      end
   end

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      rgb_d = RGB_BG;
      if (!av1_q)              rgb_d = RGB_BLANK;
      else if (hit1_q[0])      rgb_d = RGB_PLAYER;
      else if (|hit1_q[3:1])   rgb_d = RGB_ASTEROID;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hs1_q        <= SYNC_IDLE;
         vs1_q        <= SYNC_IDLE;
         av1_q        <= 1'b0;
         hit1_q       <= '0;
         hs2_q        <= SYNC_IDLE;
         vs2_q        <= SYNC_IDLE;
         rgb_q        <= RGB_BLANK;
         frame_done_q <= 1'b0;
      end else begin
         frame_done_q <= boundary;
         if (pix_en) begin
            hs1_q  <= hsync_in;
            vs1_q  <= vsync_in;
            av1_q  <= activevideo_in;
            hit1_q <= hit_d;
            hs2_q  <= hs1_q;
            vs2_q  <= vs1_q;
            rgb_q  <= rgb_d;
         end
      end
   end

   assign hsync_out  = hs2_q;
   assign vsync_out  = vs2_q;
   assign rgb        = rgb_q;
   assign frame_done = frame_done_q;

`ifdef COLLISION_DETECT_EN
   logic acc_q, collision_q, acc_set;

   // Each stage-1 pixel is counted once, in the pix_en clk that moves it to stage 2.
   assign acc_set = pix_en && av1_q && hit1_q[0] && (|hit1_q[3:1]);

   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q       <= 1'b0;
         collision_q <= 1'b0;
      end else if (boundary) begin
         collision_q <= acc_q || acc_set;
         acc_q       <= 1'b0;
      end else begin
         acc_q <= acc_q || acc_set;
      end
   end

   assign collision = collision_q;
`else
   assign collision = 1'b0;
`endif

endmodule
